// File: rtl/mul_slave.sv
// mul_slave: 32x32 -> 64-bit unsigned radix-2 shift-add multiplier behind a
// simple memory-mapped slave port. The master loads OPA/OPB, strobes start
// through CTRL, then polls STATUS or waits for m_interrupt, and finally reads
// the 64-bit product from RES_LO/RES_HI.
//
// Register map (S_addr[2:0]):
//   0 OPA      RW
//   1 OPB      RW
//   2 CTRL     W  (bit0 start, bit1 clear; self-clearing strobes), reads 0
//   3 STATUS   R  (bit0 done, bit1 busy)
//   4 RES_LO   R
//   5 RES_HI   R
//   6 INTR_EN  RW (bit0 only)
//   7 --       reads 0, writes ignored
module mul_slave (
    input  logic        clk,
    input  logic        reset,
    input  logic        S_sel,
    input  logic        S_wr,
    input  logic [7:0]  S_addr,
    input  logic [31:0] S_din,
    output logic [31:0] S_dout,
    output logic        m_interrupt
);

    // FSM encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Register addresses
    localparam logic [2:0] A_OPA     = 3'd0;
    localparam logic [2:0] A_OPB     = 3'd1;
    localparam logic [2:0] A_CTRL    = 3'd2;
    localparam logic [2:0] A_STATUS  = 3'd3;
    localparam logic [2:0] A_RES_LO  = 3'd4;
    localparam logic [2:0] A_RES_HI  = 3'd5;
    localparam logic [2:0] A_INTR_EN = 3'd6;

    // Programmer-visible registers
    logic [31:0] r_opa;
    logic [31:0] r_opb;
    logic [31:0] r_res_lo;
    logic [31:0] r_res_hi;
    logic        r_intr_en;
    logic [31:0] r_dout;
    logic        r_irq;

    // Engine state; operands are shadowed so OPA/OPB may be rewritten
    // while a multiplication is running without disturbing it.
    logic [1:0]  r_state;
    logic [31:0] r_mcand;
    logic [31:0] r_mplier;
    logic [63:0] r_acc;
    logic [4:0]  r_cnt;

    // Next-state values
    logic [1:0]  w_state_next;
    logic [31:0] w_mcand_next;
    logic [31:0] w_mplier_next;
    logic [63:0] w_acc_next;
    logic [4:0]  w_cnt_next;
    logic [31:0] w_opa_next;
    logic [31:0] w_opb_next;
    logic [31:0] w_res_lo_next;
    logic [31:0] w_res_hi_next;
    logic        w_intr_en_next;
    logic [31:0] w_dout_next;
    logic        w_irq_next;

    // Bus decode
    logic        w_wr;
    logic        w_rd;
    logic [2:0]  w_addr;
    logic        w_start;
    logic        w_clear;
    logic [31:0] w_rdata;
    logic        w_unused_addr;

    // Shift-add datapath
    logic [31:0] w_addend;
    logic [32:0] w_sum;
    logic [63:0] w_acc_shift;

    assign w_wr    = S_sel & S_wr;
    assign w_rd    = S_sel & ~S_wr;
    assign w_addr  = S_addr[2:0];
    assign w_start = w_wr && (w_addr == A_CTRL) && S_din[0];
    assign w_clear = w_wr && (w_addr == A_CTRL) && S_din[1];

    // Upper address bits are aliased onto the same eight registers.
    assign w_unused_addr = ^S_addr[7:3];

    // One iteration: conditionally add the multiplicand into the upper half
    // (33-bit sum keeps the carry), then shift the whole accumulator right
    // with that carry entering bit 63. After 32 iterations the accumulator
    // holds the full product.
    assign w_addend    = r_mplier[0] ? r_mcand : 32'd0;
    assign w_sum       = {1'b0, r_acc[63:32]} + {1'b0, w_addend};
    assign w_acc_shift = {w_sum, r_acc[31:1]};

    // Read mux: returns register contents as they stand before the edge.
    always_comb begin
        w_rdata = 32'd0;
        case (w_addr)
            A_OPA:     w_rdata = r_opa;
            A_OPB:     w_rdata = r_opb;
            A_CTRL:    w_rdata = 32'd0;
            A_STATUS:  w_rdata = {30'd0, (r_state == ST_EXEC), (r_state == ST_DONE)};
            A_RES_LO:  w_rdata = r_res_lo;
            A_RES_HI:  w_rdata = r_res_hi;
            A_INTR_EN: w_rdata = {31'd0, r_intr_en};
            default:   w_rdata = 32'd0;
        endcase
    end

    // Operand / interrupt-enable register writes and read-data capture.
    always_comb begin
        w_opa_next     = r_opa;
        w_opb_next     = r_opb;
        w_intr_en_next = r_intr_en;
        w_dout_next    = r_dout;
        if (w_wr) begin
            case (w_addr)
                A_OPA:     w_opa_next     = S_din;
                A_OPB:     w_opb_next     = S_din;
                A_INTR_EN: w_intr_en_next = S_din[0];
                default:   ;
            endcase
        end
        if (w_rd) begin
            w_dout_next = w_rdata;
        end
    end

    // Multiplier FSM and datapath next-state; clear overrides everything.
    always_comb begin
        w_state_next  = r_state;
        w_mcand_next  = r_mcand;
        w_mplier_next = r_mplier;
        w_acc_next    = r_acc;
        w_cnt_next    = r_cnt;
        w_res_lo_next = r_res_lo;
        w_res_hi_next = r_res_hi;

        case (r_state)
            ST_IDLE, ST_DONE: begin
                // Start from IDLE or DONE snapshots the current operands.
                // RES_* keeps its old value until the new run completes.
                if (w_start) begin
                    w_mcand_next  = r_opa;
                    w_mplier_next = r_opb;
                    w_acc_next    = 64'd0;
                    w_cnt_next    = 5'd0;
                    w_state_next  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // A start strobe here is deliberately ignored.
                w_acc_next    = w_acc_shift;
                w_mplier_next = {1'b0, r_mplier[31:1]};
                w_cnt_next    = r_cnt + 5'd1;
                if (r_cnt == 5'd31) begin
                    w_res_lo_next = w_acc_shift[31:0];
                    w_res_hi_next = w_acc_shift[63:32];
                    w_state_next  = ST_DONE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        if (w_clear) begin
            w_state_next  = ST_IDLE;
            w_res_lo_next = 32'd0;
            w_res_hi_next = 32'd0;
        end
    end

    // Interrupt follows the state being entered so it rises with done.
    assign w_irq_next = (w_state_next == ST_DONE) & w_intr_en_next;

    // State register with asynchronous reset that aborts any run.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_mcand   <= 32'd0;
            r_mplier  <= 32'd0;
            r_acc     <= 64'd0;
            r_cnt     <= 5'd0;
            r_opa     <= 32'd0;
            r_opb     <= 32'd0;
            r_res_lo  <= 32'd0;
            r_res_hi  <= 32'd0;
            r_intr_en <= 1'b0;
            r_dout    <= 32'd0;
            r_irq     <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_mcand   <= w_mcand_next;
            r_mplier  <= w_mplier_next;
            r_acc     <= w_acc_next;
            r_cnt     <= w_cnt_next;
            r_opa     <= w_opa_next;
            r_opb     <= w_opb_next;
            r_res_lo  <= w_res_lo_next;
            r_res_hi  <= w_res_hi_next;
            r_intr_en <= w_intr_en_next;
            r_dout    <= w_dout_next;
            r_irq     <= w_irq_next;
        end
    end

    assign S_dout      = r_dout;
    assign m_interrupt = r_irq;

endmodule

// File: tb/tb_mul_slave.sv
// tb_mul_slave: directed test of mul_slave. Reads push their expected data
// into a scoreboard queue; a monitor process pops and compares S_dout in the
// cycle after each read request.
module tb_mul_slave;

    logic        clk;
    logic        reset;
    logic        S_sel;
    logic        S_wr;
    logic [7:0]  S_addr;
    logic [31:0] S_din;
    logic [31:0] S_dout;
    logic        m_interrupt;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    logic [7:0]  tag_q[$];

    mul_slave dut (
        .clk         (clk),
        .reset       (reset),
        .S_sel       (S_sel),
        .S_wr        (S_wr),
        .S_addr      (S_addr),
        .S_din       (S_din),
        .S_dout      (S_dout),
        .m_interrupt (m_interrupt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // One bus write, occupying exactly one rising edge.
    task automatic bus_wr(input logic [7:0] a, input logic [31:0] d);
        S_sel = 1'b1; S_wr = 1'b1; S_addr = a; S_din = d;
        @(negedge clk);
        S_sel = 1'b0; S_wr = 1'b0;
    endtask

    // Write with S_sel low: must have no effect.
    task automatic bus_wr_nosel(input logic [7:0] a, input logic [31:0] d);
        S_sel = 1'b0; S_wr = 1'b1; S_addr = a; S_din = d;
        @(negedge clk);
        S_wr = 1'b0;
    endtask

    // One bus read; expected data goes to the scoreboard.
    task automatic bus_rd(input logic [7:0] a, input logic [31:0] e);
        exp_q.push_back(e);
        tag_q.push_back(a);
        S_sel = 1'b1; S_wr = 1'b0; S_addr = a; S_din = 32'd0;
        @(negedge clk);
        S_sel = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: a read sampled at a rising edge must show up on S_dout right
    // after that edge.
    initial begin
        logic        pend;
        logic [31:0] e;
        logic [7:0]  t;
        forever begin
            @(posedge clk);
            pend = S_sel & ~S_wr & ~reset;
            if (pend) begin
                @(negedge clk);
                if (exp_q.size() == 0) begin
                    check("rd_unexpected", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    t = tag_q.pop_front();
                    check($sformatf("rd[%0d]", t), {32'd0, S_dout}, {32'd0, e});
                end
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; S_sel = 1'b0; S_wr = 1'b0; S_addr = 8'd0; S_din = 32'd0;
        idle(3);
        reset = 1'b0;
        idle(1);

        // Reset state
        check("irq_after_reset", {63'd0, m_interrupt}, 64'd0);
        check("dout_after_reset", {32'd0, S_dout}, 64'd0);
        for (int a = 0; a < 8; a++) bus_rd(a[7:0], 32'd0);

        // Address aliasing, S_sel=0 ignored, read-only write ignored
        bus_wr(8'h08, 32'h0000_00AA);
        bus_rd(8'h00, 32'h0000_00AA);
        bus_wr_nosel(8'h00, 32'h0000_0055);
        bus_rd(8'hF8, 32'h0000_00AA);
        bus_wr(8'h04, 32'h0000_0123);
        bus_rd(8'h04, 32'd0);

        // 7 x 6: busy for exactly 32 cycles, then done
        bus_wr(8'd0, 32'd7);
        bus_wr(8'd1, 32'd6);
        bus_wr(8'd2, 32'd1);
        for (int k = 0; k < 32; k++) bus_rd(8'd3, 32'h2);
        bus_rd(8'd3, 32'h1);
        bus_rd(8'd4, 32'h0000_002A);
        bus_rd(8'd5, 32'd0);

        // Max x max with interrupt
        bus_wr(8'd2, 32'd2);
        bus_wr(8'd0, 32'hFFFF_FFFF);
        bus_wr(8'd1, 32'hFFFF_FFFF);
        bus_wr(8'd6, 32'd1);
        bus_wr(8'd2, 32'd1);
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            check($sformatf("irq_t+%0d", k), {63'd0, m_interrupt}, (k == 32) ? 64'd1 : 64'd0);
        end
        bus_rd(8'd6, 32'd1);
        bus_rd(8'd5, 32'hFFFF_FFFE);
        bus_rd(8'd4, 32'h0000_0001);
        bus_wr(8'd6, 32'd0);
        check("irq_intr_en_off", {63'd0, m_interrupt}, 64'd0);
        bus_wr(8'd6, 32'd1);
        check("irq_intr_en_on", {63'd0, m_interrupt}, 64'd1);
        bus_wr(8'd2, 32'd2);
        check("irq_after_clear", {63'd0, m_interrupt}, 64'd0);
        bus_rd(8'd4, 32'd0);
        bus_rd(8'd5, 32'd0);
        bus_rd(8'd3, 32'd0);

        // 3 x 5; OPA rewrite and a second start mid-run are ignored
        bus_wr(8'd6, 32'd0);
        bus_wr(8'd0, 32'd3);
        bus_wr(8'd1, 32'd5);
        bus_wr(8'd2, 32'd1);
        idle(8);
        bus_wr(8'd0, 32'd9);
        bus_wr(8'd2, 32'd1);
        for (int k = 0; k < 22; k++) bus_rd(8'd3, 32'h2);
        bus_rd(8'd3, 32'h1);
        bus_rd(8'd4, 32'h0000_000F);
        bus_rd(8'd5, 32'd0);
        bus_rd(8'd0, 32'd9);

        // Reset mid-operation
        bus_wr(8'd6, 32'd1);
        bus_wr(8'd0, 32'h1234_5678);
        bus_wr(8'd1, 32'h9ABC_DEF0);
        bus_wr(8'd2, 32'd1);
        idle(14);
        reset = 1'b1;
        #1;
        check("dout_async_reset", {32'd0, S_dout}, 64'd0);
        check("irq_async_reset", {63'd0, m_interrupt}, 64'd0);
        idle(2);
        reset = 1'b0;
        idle(1);
        for (int a = 0; a < 8; a++) bus_rd(a[7:0], 32'd0);
        bus_wr(8'd0, 32'd2);
        bus_wr(8'd1, 32'd2);
        bus_wr(8'd2, 32'd1);
        idle(32);
        bus_rd(8'd3, 32'h1);
        bus_rd(8'd4, 32'd4);
        bus_rd(8'd5, 32'd0);

        // Restart from DONE: old result held until new completion
        bus_wr(8'd0, 32'h0001_0000);
        bus_wr(8'd1, 32'h0003_0003);
        bus_wr(8'd2, 32'd1);
        bus_rd(8'd4, 32'd4);
        bus_rd(8'd3, 32'h2);
        idle(31);
        bus_rd(8'd5, 32'h0000_0003);
        bus_rd(8'd4, 32'h0003_0000);
        bus_rd(8'd3, 32'h1);

        // Start and clear together in DONE: clear wins
        bus_wr(8'd2, 32'd3);
        bus_rd(8'd3, 32'd0);
        bus_rd(8'd5, 32'd0);
        bus_rd(8'd4, 32'd0);
        check("irq_after_start_clear", {63'd0, m_interrupt}, 64'd0);

        idle(2);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_slave.md
Name: mul_slave

Overview:
- 32-bit unsigned iterative multiplier, exposed as a memory-mapped slave on the 1-master/2-slave bus.
- Connects directly downstream of the bus slave port: consumes S_sel/S_wr/S_addr/S_din and returns registered S_dout.
- The master writes two operands, pulses start, polls status or waits for the interrupt, then reads the 64-bit product as two words.

Parameters:
- None. Data width is fixed at 32 bits by the bus; the product is 64 bits.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- S_sel  input  1  slave select from bus address decoder
- S_wr  input  1  1 = write, 0 = read; valid when S_sel=1
- S_addr  input  8  word address; only S_addr[2:0] decoded
- S_din  input  32  write data
- S_dout  output  32  registered read data
- m_interrupt  output  1  done & INTR_EN[0], registered

Behaviour:
- Register map (S_addr[2:0]):
  - 0 OPA: RW
  - 1 OPB: RW
  - 2 CTRL: W only, reads 0. bit0 = start, bit1 = clear; self-clearing strobes.
  - 3 STATUS: R. bit0 = done, bit1 = busy, others 0.
  - 4 RES_LO: R
  - 5 RES_HI: R
  - 6 INTR_EN: RW, bit0 only
  - 7: reads 0, writes ignored
- Write access: S_sel=1 & S_wr=1 is sampled on a rising edge and takes effect at that edge.
  - Writes to read-only addresses are ignored.
- Read access: S_sel=1 & S_wr=0 at edge T loads S_dout at edge T; S_dout is valid during cycle T+1, matching the bus's registered select.
  - S_dout holds its value when there is no read.
  - A read of STATUS returns state as of before edge T.
- Reset values: OPA, OPB, RES_LO, RES_HI, INTR_EN, S_dout all 0; m_interrupt=0; FSM=IDLE; counter=0.
- Reset mid-operation aborts immediately to these values.
- FSM states: IDLE, EXEC, DONE.
  - IDLE, on start write:
    - Latch multiplicand=OPA and multiplier=OPB into internal shadow registers.
    - Clear the 64-bit accumulator and counter=0; go to EXEC.
  - EXEC, one iteration per cycle, radix-2 shift-add:
    - If multiplier[0], add multiplicand into accumulator[63:32] with carry.
    - Then shift accumulator right 1 (carry into bit 63) and shift multiplier right 1; counter++.
    - When counter reaches 31 (the 32nd iteration), write RES_LO/RES_HI and go to DONE.
  - DONE, on start write: relatch operands and go to EXEC. RES_* keeps the old value until the new completion.
  - Any state, on clear write: go to IDLE; RES_LO=RES_HI=0; done=0.
- Status bits: busy=1 exactly in EXEC; done=1 exactly in DONE.
- Latency: start written at edge T → busy from T; RES_* valid and done=1 after edge T+32 (32 EXEC cycles).
- Boundary conditions:
  - start while busy (EXEC): ignored; the operation continues.
  - start and clear in the same write: clear wins, FSM → IDLE.
  - OPA/OPB writes while busy: update the registers but not the running operation (shadow copies are used).
  - S_sel=0: all inputs ignored, no state change from the bus.
  - S_addr[7:3]: ignored.
- Interrupt: m_interrupt is registered as (next state == DONE) & INTR_EN[0].
  - Rises in the same cycle done rises; falls the cycle after clear, or after a start from DONE, or after an INTR_EN[0]=0 write.
- Product arithmetic: unsigned and exact; no overflow is possible in 64 bits.

Test Plan:
- Reset then read each address 0–7 → S_dout=0 in the cycle after each read; m_interrupt=0; STATUS=0.
- OPA=0x0000_0007, OPB=0x0000_0006, CTRL=1 → STATUS=0x2 for 32 cycles, then 0x1; RES_LO=0x0000_002A, RES_HI=0.
- OPA=OPB=0xFFFF_FFFF, INTR_EN=1, start → m_interrupt rises exactly 32 cycles after the start edge; RES_HI=0xFFFF_FFFE, RES_LO=0x0000_0001; CTRL=2 → m_interrupt=0, RES_*=0, STATUS=0.
- Start with 3×5, then at cycle 10 write OPA=9 and write CTRL=1 again → ignored; result 0x0F at the original completion time.
- Start with 0x1234_5678 × 0x9ABC_DEF0, assert reset at cycle 15 → all registers 0, FSM IDLE; a new 2×2 run after release yields 4.
- CTRL=3 written in DONE → IDLE, done=0; reading RES_HI then RES_LO back-to-back → each value appears exactly one cycle after its request.
